// File: rtl/led_trail_fader.sv
// Ten-LED scanner trail: each LED holds a 4-bit brightness that is reloaded by the
// scanner position and decays periodically; brightness is rendered as PWM on LEDR.
module led_trail_fader #(
  parameter int PWM_PRESCALE = 1,
  parameter int DECAY_PERIOD = 1000000
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic [9:0] pos_onehot,
  input  logic       trail_en,
  output logic [9:0] LEDR,
  output logic       active
);

  localparam int PRE_W = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
  localparam int DCY_W = $clog2(DECAY_PERIOD);

  logic [PRE_W-1:0]  pre_cnt;
  logic [3:0]        pwm_cnt;
  logic [DCY_W-1:0]  dcy_cnt;
  logic [9:0][3:0]   lvl;

  logic              pwm_step;
  logic              decay_tick;
  logic [9:0]        pwm_bits;
  logic              any_lit;

  // Brightness never wraps from 0 back to full.
  function automatic logic [3:0] sat_dec(input logic [3:0] v);
    return (v == 4'd0) ? 4'd0 : v - 4'd1;
  endfunction

  assign pwm_step   = (pre_cnt == PRE_W'(PWM_PRESCALE - 1));
  assign decay_tick = (dcy_cnt == DCY_W'(DECAY_PERIOD - 1));

  always_comb begin
    pwm_bits = '0;
    any_lit  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pwm_bits[i] = (pwm_cnt < lvl[i]);
      any_lit     = any_lit | (lvl[i] != 4'd0);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
      dcy_cnt <= '0;
      lvl     <= '0;
      LEDR    <= '0;
      active  <= 1'b0;
    end else begin
      pre_cnt <= pwm_step ? '0 : pre_cnt + PRE_W'(1);
      if (pwm_step)
        pwm_cnt <= pwm_cnt + 4'd1;
      dcy_cnt <= decay_tick ? '0 : dcy_cnt + DCY_W'(1);
      // A load always beats a coincident decay tick.
      for (int i = 0; i < 10; i++) begin
        if (pos_onehot[i])
          lvl[i] <= 4'd15;
        else if (decay_tick)
          lvl[i] <= sat_dec(lvl[i]);
      end
      LEDR   <= trail_en ? pwm_bits : pos_onehot;
      active <= any_lit;
    end
  end

endmodule

// File: tb/tb_led_trail_fader.sv
// Directed bench for led_trail_fader with DECAY_PERIOD=4, PWM_PRESCALE=1.
module tb_led_trail_fader;
  localparam int DP = 4;
  localparam int PP = 1;

  logic       CLOCK_50 = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] pos_onehot = '0;
  logic       trail_en = 1'b1;
  logic [9:0] LEDR;
  logic       active;

  led_trail_fader #(.PWM_PRESCALE(PP), .DECAY_PERIOD(DP)) dut (
    .CLOCK_50  (CLOCK_50),
    .reset_n   (reset_n),
    .pos_onehot(pos_onehot),
    .trail_en  (trail_en),
    .LEDR      (LEDR),
    .active    (active)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_fail = 0;

  int             m_dcy = 0;
  int             m_pwm = 0;
  logic [9:0][3:0] m_lvl = '0;
  logic [9:0]     m_ledr = '0;
  logic           m_act = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge: predict from pre-edge inputs/state, then compare after the edge.
  task automatic step();
    logic [9:0][3:0] nl;
    logic [9:0]      nled;
    logic            nact;
    logic            tick;
    logic            rst_now;
    rst_now = !reset_n;
    tick = (m_dcy == DP - 1);
    nact = 1'b0;
    for (int i = 0; i < 10; i++) begin
      nled[i] = trail_en ? (m_pwm < int'(m_lvl[i])) : pos_onehot[i];
      if (m_lvl[i] != 4'd0) nact = 1'b1;
      if (pos_onehot[i]) nl[i] = 4'd15;
      else if (tick && m_lvl[i] != 4'd0) nl[i] = m_lvl[i] - 4'd1;
      else nl[i] = m_lvl[i];
    end
    @(posedge CLOCK_50);
    #1;
    if (rst_now) begin
      m_lvl = '0; m_ledr = '0; m_act = 1'b0; m_dcy = 0; m_pwm = 0;
    end else begin
      m_lvl = nl; m_ledr = nled; m_act = nact;
      m_dcy = tick ? 0 : m_dcy + 1;
      m_pwm = (m_pwm + 1) % 16;
    end
    check("ledr_model", 64'(LEDR), 64'(m_ledr));
    check("active_model", 64'(active), 64'(m_act));
    check("lvl_model", 64'(dut.lvl), 64'(m_lvl));
  endtask

  initial begin
    int ones;
    int lit;
    logic ok;

    // Reset held with every position bit set
    reset_n = 1'b0; pos_onehot = 10'h3FF; trail_en = 1'b1;
    repeat (3) step();
    check("rst_ledr", 64'(LEDR), 64'h0);
    check("rst_active", 64'(active), 64'h0);
    check("rst_lvl", 64'(dut.lvl), 64'h0);

    // Release with a single-cycle load of LED0; first decay lands on the 4th edge
    reset_n = 1'b1; pos_onehot = 10'h001;
    step();
    check("load_lvl0", 64'(dut.lvl[0]), 64'd15);
    pos_onehot = '0;
    step(); step();
    check("pre_tick_lvl0", 64'(dut.lvl[0]), 64'd15);
    step();
    check("first_tick_lvl0", 64'(dut.lvl[0]), 64'd14);
    for (int k = 1; k <= 14; k++) begin
      repeat (4) step();
      check("decay_lvl0", 64'(dut.lvl[0]), 64'(14 - k));
    end
    check("active_at_zero", 64'(active), 64'd1);
    step();
    check("active_drop", 64'(active), 64'd0);
    repeat (4) step();
    check("sat_lvl0", 64'(dut.lvl[0]), 64'd0);

    // Load beats decay tick, and full level gives 15/16 duty
    pos_onehot = 10'h008;
    step();
    for (int k = 0; k < 8; k++) begin
      step();
      check("load_wins_lvl3", 64'(dut.lvl[3]), 64'd15);
    end
    ones = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      ones += int'(LEDR[3]);
    end
    check("duty_15", 64'(ones), 64'd15);
    pos_onehot = '0;

    // Scanner sweep up then down
    for (int p = 0; p < 10; p++) begin
      pos_onehot = 10'(1 << p);
      repeat (8) step();
      ok = 1'b1;
      for (int j = 1; j <= p; j++)
        if (dut.lvl[j-1] > dut.lvl[j]) ok = 1'b0;
      check("sweep_up_mono", 64'(ok), 64'd1);
    end
    for (int p = 8; p >= 0; p--) begin
      pos_onehot = 10'(1 << p);
      repeat (8) step();
      ok = 1'b1;
      for (int j = p; j <= 8; j++)
        if (dut.lvl[j+1] > dut.lvl[j]) ok = 1'b0;
      check("sweep_dn_mono", 64'(ok), 64'd1);
    end

    // Pass-through and return to trail mode
    trail_en = 1'b0; pos_onehot = 10'h200;
    step();
    check("pass_ledr", 64'(LEDR), 64'h200);
    trail_en = 1'b1; pos_onehot = '0;
    step();
    step();

    // Reset mid-fade with five lit LEDs
    pos_onehot = 10'h01F;
    step();
    pos_onehot = '0;
    step();
    lit = 0;
    for (int i = 0; i < 5; i++) lit += int'(dut.lvl[i] != 4'd0);
    check("five_lit", 64'(lit), 64'd5);
    check("active_before_rst", 64'(active), 64'd1);
    reset_n = 1'b0;
    step();
    check("midrst_ledr", 64'(LEDR), 64'h0);
    check("midrst_active", 64'(active), 64'h0);
    check("midrst_lvl", 64'(dut.lvl), 64'h0);
    reset_n = 1'b1;
    ones = 0;
    lit = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      ones += int'(LEDR != 10'h0);
      lit += int'(active);
    end
    check("post_rst_ledr_quiet", 64'(ones), 64'd0);
    check("post_rst_active_quiet", 64'(lit), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_trail_fader.md
LED_TRAIL_FADER -- requirements
Module: led_trail_fader

Interface
REQ-001 Parameter PWM_PRESCALE, default 1: clock cycles per PWM step, legal range 1 or more.
REQ-002 Parameter DECAY_PERIOD, default 1000000: clock cycles per brightness decay step, legal range 2 or more.
REQ-003 Port CLOCK_50, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset_n, input, 1 bit: synchronous, active-low reset, sampled on the CLOCK_50 rising edge.
REQ-005 Port pos_onehot, input, 10 bits: scanner position pattern, level-sensitive, sampled every cycle; bit i set loads LED i.
REQ-006 Port trail_en, input, 1 bit: 1 selects fading-trail output; 0 selects plain registered pass-through.
REQ-007 Port LEDR, output, 10 bits: registered LED drive, PWM-modulated when trail_en=1.
REQ-008 Port active, output, 1 bit: registered; 1 when any brightness level is nonzero.

Function
REQ-009 State: ten 4-bit levels lvl[0..9], a prescale counter, a 4-bit pwm_cnt, and a decay counter sized to hold DECAY_PERIOD-1.
REQ-010 Prescale counter: counts 0..PWM_PRESCALE-1 and wraps; pwm_step=1 in the wrap cycle (every cycle when PWM_PRESCALE=1).
REQ-011 pwm_cnt: increments by 1 on pwm_step; wraps 15->0; holds otherwise.
REQ-012 Decay counter: counts 0..DECAY_PERIOD-1 and wraps; decay_tick=1 in the cycle the counter equals DECAY_PERIOD-1.
REQ-013 Load: when pos_onehot[i]=1 at an edge, lvl[i] becomes 15 after that edge, regardless of decay_tick.
REQ-014 Decay: when decay_tick=1 and pos_onehot[i]=0, lvl[i] decrements by 1, saturating at 0 (never wraps to 15).
REQ-015 Otherwise lvl[i] holds.
REQ-016 Multiple set bits in pos_onehot are legal; every set bit loads independently; no one-hot check.
REQ-017 LEDR when trail_en=1: LEDR[i] is registered as (pwm_cnt < lvl[i]) using the pre-edge values.
REQ-018 Duty cycle: lvl=15 gives 15/16 duty; lvl=0 gives LED off.
REQ-019 LEDR when trail_en=0: LEDR is registered as pos_onehot (1-cycle latency).
REQ-020 trail_en=0 does not freeze state: levels, counters and active keep updating.
REQ-021 Toggling trail_en takes effect on the next LEDR update, with no glitch cycle.
REQ-022 active is registered as the OR over i of (lvl[i] != 0), using the pre-edge levels.
REQ-023 Latency, pos_onehot[i] rising: lvl[i]=15 after edge N, and LEDR[i] reflects it after edge N+1.

Reset
REQ-024 When reset_n=0 at an edge, the following all become 0 after that edge: every lvl, the prescale counter, pwm_cnt, the decay counter, LEDR and active.
REQ-025 Reset overrides load, decay and trail_en.
REQ-026 Reset mid-fade discards all trails; no output is driven from pre-reset state.
REQ-027 After reset_n returns to 1, the first decay_tick occurs DECAY_PERIOD cycles later and the first pwm_step occurs PWM_PRESCALE cycles later.

Verification (bench params DECAY_PERIOD=4, PWM_PRESCALE=1)
REQ-028 Reset: hold reset_n=0 for 3 cycles with pos_onehot=10'h3FF -> LEDR=0, active=0, all levels 0; release, first decay_tick on the 4th cycle.
REQ-029 Single load and decay: pulse pos_onehot=10'h001 for 1 cycle, then 0 -> lvl[0]=15, then 14, 13, ... decrementing every 4 cycles down to 0 and holding at 0; active drops 1 cycle after lvl[0] reaches 0; LEDR[0] duty over each 16-cycle window equals lvl/16.
REQ-030 Load wins: assert pos_onehot[3]=1 in the same cycle as decay_tick with lvl[3]=15 -> lvl[3] stays 15.
REQ-031 Scanner sweep: step a one-hot bit 0->9->0, holding each position 8 cycles -> trailing LEDs show strictly non-increasing levels behind the head; no level underflows.
REQ-032 Pass-through: set trail_en=0 and pos_onehot=10'h200 -> LEDR=10'h200 one cycle later; return trail_en=1 -> LEDR follows the PWM of the current levels on the next edge.
REQ-033 Reset mid-operation: assert reset_n=0 while 5 LEDs have nonzero levels -> all zero after that edge, with no residual LEDR activity after release.
